chunked_seq_adder: RTL and testbench
====================================

Name: chunked_seq_adder

Overview:
- Multi-cycle N-bit adder/subtractor with valid/ready handshakes on input and output.
- Computes the result in W-bit slices, one slice per clock, starting at the LSB slice. Carry is held in a flop between slices.
- Trades latency for area and timing: only one W-bit ripple chain, against a full N-bit chain evaluated in one cycle.
- Sits wherever wide datapath adds (1024-bit class) must close timing at high clock rates.

Parameters:
- N, 1024, operand and result width in bits.
- W, 64, slice width in bits. Legal when 1 <= W <= N and N % W == 0; otherwise elaboration fails via a generate-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  N  operand A.
- b  input  N  operand B.
- sub  input  1  0 = add, 1 = subtract.
- c_in  input  1  carry-in; used in add mode only.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  N  result.
- c_out  output  1  carry-out of bit N-1.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Derived constants:
  - NCH = N/W.
  - Slice counter width is max(1, clog2(NCH)).
- Reset (rst_n=0 at a clk edge):
  - State = IDLE; in_ready=1, out_valid=0, sum=0, c_out=0.
  - Slice counter = 0, carry flop = 0, operand registers = 0.
  - Applies in any state. An in-flight op is discarded, with no output.
- Arithmetic:
  - sub=0: {c_out,sum} = A + B + c_in.
  - sub=1: {c_out,sum} = A + ~B + 1, i.e. A - B mod 2^N. c_in is ignored; c_out=1 means no borrow (A >= B unsigned).
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid & in_ready:
    - Register A into opA, and B (sub ? ~B : B) into opB.
    - Set carry = sub ? 1 : c_in.
    - Set counter = 0.
    - Go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, k = counter:
    - {carry, sum[k*W +: W]} = opA[k*W +: W] + opB[k*W +: W] + carry.
    - If k == NCH-1: c_out <= carry-out, go to DONE. Otherwise counter++.
  - DONE: in_ready=0, out_valid=1. sum and c_out are held stable. On out_ready=1 go to IDLE.
- Timing:
  - Accept edge E0. out_valid rises after edge E_NCH, i.e. NCH cycles after accept.
  - Minimum issue interval is NCH+2 cycles: accept, NCH RUN cycles, one DONE cycle with out_ready=1, return to IDLE.
  - NCH=1 (W=N): a single RUN cycle.
- Handshake rules:
  - Operands are sampled only at the accept edge. a, b, sub and c_in may change freely afterwards.
  - in_valid during RUN or DONE is ignored (in_ready=0). The source must hold it until accepted.
  - out_ready has no effect outside DONE. If out_ready is held high in DONE, out_valid stays high for exactly one cycle.
  - Backpressure: DONE is held indefinitely while out_ready=0.
- sum is checked only while out_valid=1. Intermediate slice updates during RUN are not part of the contract.
- Wrap-around: overflow past bit N-1 is reported only through c_out.

Optional Feature:
- Macro CSA_SIGNED_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit).
  - Set in the final RUN cycle: ovf = (opA[N-1] == opB[N-1]) & (sum_msb != opA[N-1]). This is two's-complement signed overflow of the effective operation.
  - Reset value 0; held with sum in DONE.
- When undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
1. N=16, W=4. Reset, then a=16'hFFFF, b=16'h0001, sub=0, c_in=0 -> out_valid exactly 4 cycles after accept; sum=16'h0000, c_out=1.
2. N=16, W=4. a=16'h1234, b=16'h0234, sub=1, c_in=1 -> sum=16'h1000, c_out=1 (c_in ignored). Then a=16'h0001, b=16'h0002, sub=1 -> sum=16'hFFFF, c_out=0.
3. N=1024, W=64. a=all-ones, b=0, c_in=1 -> full carry ripple through all 16 slices; sum=0, c_out=1, out_valid at cycle 16 after accept.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> sum and c_out stable, in_ready=0. Pulse in_valid with new operands -> not accepted. out_ready=1 -> IDLE next cycle; the queued in_valid is accepted the following edge.
5. Reset mid-op: assert rst_n=0 in RUN at slice 2 -> next edge out_valid=0, sum=0, c_out=0, in_ready=1. A new op then completes correctly.
6. With CSA_SIGNED_OVF_EN, N=16, W=8: a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, ovf=1. a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, ovf=1. a=16'h0005, b=16'h0003, sub=1 -> ovf=0.

Source files
------------

// File: rtl/chunked_seq_adder_if.sv
// chunked_seq_adder_if: operand/result handshake bundle for chunked_seq_adder (N-bit operands and sum).
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side. ovf exists only with CSA_SIGNED_OVF_EN.
interface chunked_seq_adder_if #(
  parameter int N = 1024
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
`ifdef CSA_SIGNED_OVF_EN
  logic         ovf;
`endif

  // Source/consumer side: presents operands, accepts results.
  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
`ifdef CSA_SIGNED_OVF_EN
    , input ovf
`endif
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
`ifdef CSA_SIGNED_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder: N-bit add/subtract evaluated W bits per clock from the LSB slice, carry kept in a flop.
// Latency: result valid NCH = N/W cycles after the accept edge; back-to-back accepts are NCH+2 cycles apart.
// Backpressure: in_ready only while IDLE; the result is held in DONE until out_ready. Macro CSA_SIGNED_OVF_EN adds ovf.
module chunked_seq_adder #(
  parameter int N = 1024,
  parameter int W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  chunked_seq_adder_if.slave bus
);
  localparam int NCH = (W >= 1) ? (N / W) : 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (W < 1) begin : g_bad_w_small
      $error("chunked_seq_adder: W must be at least 1");
    end else if ((W > N) || ((N % W) != 0)) begin : g_bad_w_div
      $error("chunked_seq_adder: W must divide N and not exceed it");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  // Operands shift right one slice per RUN cycle so the active slice is always at [W-1:0].
  logic [N-1:0]  r_opa;
  logic [N-1:0]  r_opb;
  // Result slices enter at the top and shift down; after NCH slices the word is aligned.
  logic [N-1:0]  r_sum;
  logic [N-1:0]  w_sum_nxt;
  logic          r_cout;
  logic [W-1:0]  w_slice_sum;
  logic          w_slice_co;
  logic          w_last;
`ifdef CSA_SIGNED_OVF_EN
  logic          r_ovf;
`endif

  // The single W-bit ripple chain shared by every slice.
  assign {w_slice_co, w_slice_sum} = {1'b0, r_opa[W-1:0]} + {1'b0, r_opb[W-1:0]} + {{W{1'b0}}, r_carry};
  assign w_last = (r_cnt == CW'(NCH - 1));

  generate
    if (NCH == 1) begin : g_one_slice
      assign w_sum_nxt = w_slice_sum;
    end else begin : g_multi_slice
      assign w_sum_nxt = {w_slice_sum, r_sum[N-1:W]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, walk slices in RUN, hold result in DONE until taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)       w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, add one slice per RUN cycle, freeze in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef CSA_SIGNED_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_opa   <= bus.a;
            // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
            r_opb   <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.c_in;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_opa   <= r_opa >> W;
          r_opb   <= r_opb >> W;
          r_sum   <= w_sum_nxt;
          r_carry <= w_slice_co;
          if (w_last) begin
            r_cout <= w_slice_co;
`ifdef CSA_SIGNED_OVF_EN
            // Top slice is at [W-1:0] now, so bit W-1 is the operand sign.
            r_ovf  <= (r_opa[W-1] == r_opb[W-1]) & (w_slice_sum[W-1] != r_opa[W-1]);
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_cout;
`ifdef CSA_SIGNED_OVF_EN
  assign bus.ovf       = r_ovf;
`endif
endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb_chunked_seq_adder: three adder instances (16/4, 1024/64, 16/8) driven with directed vectors.
// Expected results are queued at issue time and popped by per-instance monitors on out_valid & out_ready.
// Covers reset, add/sub, full ripple, issue interval, backpressure, mid-op reset and (with CSA_SIGNED_OVF_EN) ovf.
module tb_chunked_seq_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chunked_seq_adder_if #(.N(16))   if_a ();
  chunked_seq_adder_if #(.N(1024)) if_b ();
  chunked_seq_adder_if #(.N(16))   if_c ();

  chunked_seq_adder #(.N(16),   .W(4))  u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  chunked_seq_adder #(.N(1024), .W(64)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  chunked_seq_adder #(.N(16),   .W(8))  u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic ovf_a, ovf_b, ovf_c;
`ifdef CSA_SIGNED_OVF_EN
  assign ovf_a = if_a.ovf;
  assign ovf_b = if_b.ovf;
  assign ovf_c = if_c.ovf;
`else
  assign ovf_a = 1'b0;
  assign ovf_b = 1'b0;
  assign ovf_c = 1'b0;
`endif

  typedef struct {
    logic [1023:0] sum;
    logic          co;
    logic          ov;
    int            acc;
    int            nch;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic pv_a = 1'b0;
  logic pv_b = 1'b0;
  logic pv_c = 1'b0;
  logic [1023:0] ones = '1;

  function automatic logic [1023:0] w16(input logic [15:0] v);
    return {1008'b0, v};
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t qfront(input int id);
    case (id)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic exp_t qpop(input int id);
    case (id)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qdrop_last(input int id);
    exp_t e;
    case (id)
      0:       e = q0.pop_back();
      1:       e = q1.pop_back();
      default: e = q2.pop_back();
    endcase
  endfunction

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act_hi=%h act_lo=%h exp_hi=%h exp_lo=%h",
               nm, act[1023:896], act[127:0], exp[1023:896], exp[127:0]);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 1024'(act), 1024'(exp));
  endtask

  function automatic logic rdy_of(input int id);
    case (id)
      0:       return if_a.in_ready;
      1:       return if_b.in_ready;
      default: return if_c.in_ready;
    endcase
  endfunction

  task automatic drive(input int id, input logic v, input logic [1023:0] a, input logic [1023:0] b,
                       input logic s, input logic ci);
    case (id)
      0: begin
        if_a.in_valid = v; if_a.a = a[15:0]; if_a.b = b[15:0]; if_a.sub = s; if_a.c_in = ci;
      end
      1: begin
        if_b.in_valid = v; if_b.a = a; if_b.b = b; if_b.sub = s; if_b.c_in = ci;
      end
      default: begin
        if_c.in_valid = v; if_c.a = a[15:0]; if_c.b = b[15:0]; if_c.sub = s; if_c.c_in = ci;
      end
    endcase
  endtask

  // Call at posedge+#1. Returns at posedge+#1 just after the accept edge.
  task automatic issue(input int id, input logic [1023:0] a, input logic [1023:0] b,
                       input logic s, input logic ci, input logic [1023:0] es,
                       input logic eco, input logic eov, input int nch, output int acc);
    exp_t e;
    acc = -1;
    drive(id, 1'b1, a, b, s, ci);
    for (int n = 0; n < 200 && acc < 0; n++) begin
      if (rdy_of(id)) begin
        acc   = cyc + 1;
        e.sum = es; e.co = eco; e.ov = eov; e.acc = acc; e.nch = nch;
        qpush(id, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL accept_timeout id=%0d act=0 exp=1", id);
    end
    // Scramble operands after the accept edge; the adder must not look at them again.
    drive(id, 1'b0, ~a, ~b, ~s, ~ci);
  endtask

  task automatic wait_drain(input int id);
    int n;
    n = 0;
    while (qsize(id) != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (qsize(id) != 0) begin
      errors++;
      $display("FAIL drain_timeout id=%0d act=%0d exp=0", id, qsize(id));
    end
  endtask

  task automatic mon_step(input int id, input logic prev, input logic vld, input logic rdy,
                          input logic [1023:0] s, input logic co, input logic ov);
    exp_t e;
    if (vld && !prev) begin
      if (qsize(id) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid id=%0d act=1 exp=0", id);
      end else begin
        e = qfront(id);
        chk($sformatf("latency_id%0d", id), 1024'(cyc - e.acc), 1024'(e.nch));
      end
    end
    if (vld && rdy && qsize(id) != 0) begin
      e = qpop(id);
      chk($sformatf("sum_id%0d", id), s, e.sum);
      chk1($sformatf("c_out_id%0d", id), co, e.co);
`ifdef CSA_SIGNED_OVF_EN
      chk1($sformatf("ovf_id%0d", id), ov, e.ov);
`else
      if (ov !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL ovf_tie id=%0d act=%b exp=0", id, ov);
      end
`endif
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, pv_a, if_a.out_valid, if_a.out_ready, 1024'(if_a.sum), if_a.c_out, ovf_a);
    pv_a = if_a.out_valid;
  end
  always @(negedge clk) begin
    mon_step(1, pv_b, if_b.out_valid, if_b.out_ready, if_b.sum, if_b.c_out, ovf_b);
    pv_b = if_b.out_valid;
  end
  always @(negedge clk) begin
    mon_step(2, pv_c, if_c.out_valid, if_c.out_ready, 1024'(if_c.sum), if_c.c_out, ovf_c);
    pv_c = if_c.out_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1;
    int acc2;
    int n;

    rst_n = 1'b0;
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b1;
    if_c.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state on every instance.
    chk1("rst_in_ready_a", if_a.in_ready, 1'b1);
    chk1("rst_out_valid_a", if_a.out_valid, 1'b0);
    chk("rst_sum_a", 1024'(if_a.sum), '0);
    chk1("rst_c_out_a", if_a.c_out, 1'b0);
    chk1("rst_in_ready_b", if_b.in_ready, 1'b1);
    chk1("rst_out_valid_b", if_b.out_valid, 1'b0);
    chk("rst_sum_b", if_b.sum, '0);
    chk1("rst_in_ready_c", if_c.in_ready, 1'b1);
    chk1("rst_out_valid_c", if_c.out_valid, 1'b0);
    chk1("rst_ovf_c", ovf_c, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 16/4: wrap to zero with carry out.
    issue(0, w16(16'hFFFF), w16(16'h0001), 1'b0, 1'b0, w16(16'h0000), 1'b1, 1'b0, 4, acc1);
    wait_drain(0);
    // 16/4: subtract ignores c_in; borrow case gives c_out=0.
    issue(0, w16(16'h1234), w16(16'h0234), 1'b1, 1'b1, w16(16'h1000), 1'b1, 1'b0, 4, acc1);
    issue(0, w16(16'h0001), w16(16'h0002), 1'b1, 1'b0, w16(16'hFFFF), 1'b0, 1'b0, 4, acc1);
    wait_drain(0);
    // 16/4: back-to-back issue spacing, add with c_in, signed-overflowing add.
    issue(0, w16(16'h1234), w16(16'h4321), 1'b0, 1'b1, w16(16'h5556), 1'b0, 1'b0, 4, acc1);
    issue(0, w16(16'h8000), w16(16'h8000), 1'b0, 1'b0, w16(16'h0000), 1'b1, 1'b1, 4, acc2);
    chk("issue_interval", 1024'(acc2 - acc1), 1024'(6));
    wait_drain(0);

    // 1024/64: carry ripples through all 16 slices; then 0 - 1.
    issue(1, ones, '0, 1'b0, 1'b1, '0, 1'b1, 1'b0, 16, acc1);
    issue(1, '0, 1024'(1), 1'b1, 1'b0, ones, 1'b0, 1'b0, 16, acc1);
    wait_drain(1);

    // 16/8: signed overflow cases and a clean subtract.
    issue(2, w16(16'h7FFF), w16(16'h0001), 1'b0, 1'b0, w16(16'h8000), 1'b0, 1'b1, 2, acc1);
    issue(2, w16(16'h8000), w16(16'h0001), 1'b1, 1'b0, w16(16'h7FFF), 1'b1, 1'b1, 2, acc1);
    issue(2, w16(16'h0005), w16(16'h0003), 1'b1, 1'b0, w16(16'h0002), 1'b1, 1'b0, 2, acc1);
    wait_drain(2);

    // Backpressure on 16/4: result held for 10 cycles, new request ignored until drained.
    if_a.out_ready = 1'b0;
    issue(0, w16(16'h00FF), w16(16'h0001), 1'b0, 1'b0, w16(16'h0100), 1'b0, 1'b0, 4, acc1);
    n = 0;
    while (!if_a.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk1("bp_out_valid", if_a.out_valid, 1'b1);
      chk1("bp_in_ready", if_a.in_ready, 1'b0);
      chk("bp_sum", 1024'(if_a.sum), w16(16'h0100));
      chk1("bp_c_out", if_a.c_out, 1'b0);
      if (i == 3) drive(0, 1'b1, w16(16'h0003), w16(16'h0004), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    if_a.out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("bp_release_in_ready", if_a.in_ready, 1'b1);
    chk1("bp_release_out_valid", if_a.out_valid, 1'b0);
    begin
      exp_t e;
      e.sum = w16(16'h0007); e.co = 1'b0; e.ov = 1'b0; e.acc = cyc + 1; e.nch = 4;
      qpush(0, e);
    end
    @(posedge clk); #1;
    chk1("bp_queued_accepted", if_a.in_ready, 1'b0);
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    wait_drain(0);

    // Reset in the middle of RUN (counter at slice 2) discards the op.
    issue(0, w16(16'h1111), w16(16'h2222), 1'b0, 1'b0, w16(16'h3333), 1'b0, 1'b0, 4, acc1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    qdrop_last(0);
    chk1("midrst_out_valid", if_a.out_valid, 1'b0);
    chk("midrst_sum", 1024'(if_a.sum), '0);
    chk1("midrst_c_out", if_a.c_out, 1'b0);
    chk1("midrst_in_ready", if_a.in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, w16(16'h0F0F), w16(16'h00F1), 1'b0, 1'b0, w16(16'h1000), 1'b0, 1'b0, 4, acc1);
    wait_drain(0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
